// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
// Optional feature macro: PISO_PARITY_EN adds an even-parity bit after each word.
package piso_pkg;

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

   // Bit-order selector values; the receiver uses the same encoding.
   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the serial transmitter.
// Counts the data bit currently on the serial line and flags the final
// position (TERM) as well as the position just before it, so the owner can
// register its end-of-word outputs one cycle ahead.
module piso_bit_cnt #(
   parameter int CNT_W = 3,
   parameter int TERM  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic last,
   output logic near_last
);

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERM);
   localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(TERM - 1);

   logic [CNT_W-1:0] cnt;

   // Up-counter; clear wins over enable so a new word always restarts at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last      = (cnt == TERM_CNT);
   assign near_last = (cnt == PRE_CNT);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter.
// Accepts one word per valid/ready handshake and shifts it out one bit per
// clock, MSB-first or LSB-first as selected at accept time. All outputs are
// registered; the first bit appears the cycle after the accepting edge.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit cycle.
module piso_shift_tx
   import piso_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             rl_mode,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic             dir;
   logic             accept;
   logic             cnt_en;
   logic             cnt_last;
   logic             cnt_near_last;
   logic             load_bit;
   logic [WIDTH-1:0] load_sreg;
   logic             shift_bit;
   logic [WIDTH-1:0] shift_sreg;
`ifdef PISO_PARITY_EN
   logic             parity_bit;
`endif

   assign accept = load_valid & load_ready;
   assign cnt_en = (state == SHIFT) && !cnt_last;

   piso_bit_cnt #(
      .CNT_W (CNT_W),
      .TERM  (WIDTH - 1)
   ) u_bit_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .en        (cnt_en),
      .last      (cnt_last),
      .near_last (cnt_near_last)
   );

   // First bit and remaining-bit image for a freshly accepted word, plus the
   // next bit and shifted image for a word already in flight.
   always_comb begin
      load_bit   = 1'b0;
      load_sreg  = '0;
      shift_bit  = 1'b0;
      shift_sreg = '0;
      if (rl_mode == DIR_MSB_FIRST) begin
         load_bit  = din[WIDTH-1];
         load_sreg = {din[WIDTH-2:0], 1'b0};
      end else begin
         load_bit  = din[0];
         load_sreg = {1'b0, din[WIDTH-1:1]};
      end
      if (dir == DIR_MSB_FIRST) begin
         shift_bit  = sreg[WIDTH-1];
         shift_sreg = {sreg[WIDTH-2:0], 1'b0};
      end else begin
         shift_bit  = sreg[0];
         shift_sreg = {1'b0, sreg[WIDTH-1:1]};
      end
   end

   // Control FSM with registered outputs; end-of-word flags are set one edge
   // early so done and load_ready line up with the final bit on the wire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sreg       <= '0;
         dir        <= DIR_LSB_FIRST;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            state      <= SHIFT;
            dir        <= rl_mode;
            sreg       <= load_sreg;
            sout       <= load_bit;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit <= ^din;
`endif
         end else begin
            case (state)
               IDLE: begin
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  busy       <= 1'b0;
                  load_ready <= 1'b1;
               end
               SHIFT: begin
                  if (cnt_last) begin
`ifdef PISO_PARITY_EN
                     state      <= PARITY;
                     sout       <= parity_bit;
                     sout_valid <= 1'b1;
                     busy       <= 1'b1;
                     done       <= 1'b1;
                     load_ready <= 1'b1;
`else
                     state      <= IDLE;
                     sout       <= 1'b0;
                     sout_valid <= 1'b0;
                     busy       <= 1'b0;
                     load_ready <= 1'b1;
`endif
                  end else begin
                     sreg       <= shift_sreg;
                     sout       <= shift_bit;
                     sout_valid <= 1'b1;
                     busy       <= 1'b1;
`ifdef PISO_PARITY_EN
                     load_ready <= 1'b0;
`else
                     done       <= cnt_near_last;
                     load_ready <= cnt_near_last;
`endif
                  end
               end
`ifdef PISO_PARITY_EN
               PARITY: begin
                  state      <= IDLE;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  busy       <= 1'b0;
                  load_ready <= 1'b1;
               end
`endif
               default: begin
                  state      <= IDLE;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  busy       <= 1'b0;
                  load_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx (WIDTH=4).
// Honours PISO_PARITY_EN to select the expected framing.
module tb_piso_shift_tx;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] din = '0;
   logic         load_valid = 1'b0;
   logic         rl_mode = 1'b0;
   logic         load_ready;
   logic         sout;
   logic         sout_valid;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   piso_shift_tx #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .rl_mode    (rl_mode),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done)
   );

   // Expected per-cycle output record: {sout, valid, busy, done, ready}.
   typedef struct packed {
      logic sout;
      logic valid;
      logic busy;
      logic done;
      logic ready;
   } out_rec_t;

   typedef struct {
      logic [W-1:0] din;
      logic         valid;
      logic         mode;
      logic         e_sout;
      logic         e_valid;
      logic         e_done;
   } vec_t;

   out_rec_t exp_cur;
   out_rec_t pend[$];
   vec_t     tbl[$];
   int       n_compared = 0;
   int       n_mismatched = 0;

   // Reference model: a word becomes a list of output cycles, one per bit
   // in transmit order, with an optional trailing parity cycle.
   function automatic void build_word(input logic [W-1:0] d, input logic m);
      out_rec_t r;
      int       idx;
      pend.delete();
      for (int k = 0; k < W; k++) begin
         idx     = m ? (W - 1 - k) : k;
         r.sout  = d[idx];
         r.valid = 1'b1;
         r.busy  = 1'b1;
         r.done  = (k == W - 1) && !PAR;
         r.ready = (k == W - 1) && !PAR;
         pend.push_back(r);
      end
      if (PAR) begin
         r.sout  = ^d;
         r.valid = 1'b1;
         r.busy  = 1'b1;
         r.done  = 1'b1;
         r.ready = 1'b1;
         pend.push_back(r);
      end
   endfunction

   task automatic checkOutput(input string name, input out_rec_t expv);
      out_rec_t act;
      act = {sout, sout_valid, busy, done, load_ready};
      n_compared++;
      if (act !== expv) begin
         n_mismatched++;
         $display("[TB] FAIL %s: sout/valid/busy/done/ready got %b required %b", name, act, expv);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic m, input string name);
      din        = d;
      load_valid = v;
      rl_mode    = m;
      if (v && exp_cur.ready) build_word(d, m);
      if (pend.size() > 0) exp_cur = pend.pop_front();
      else exp_cur = 5'b00001;
      @(posedge clk);
      #1;
      checkOutput(name, exp_cur);
   endtask

   function automatic void add_vec(input logic [W-1:0] d, input logic v, input logic m,
                                   input logic es, input logic ev, input logic ed);
      vec_t x;
      x.din = d; x.valid = v; x.mode = m;
      x.e_sout = es; x.e_valid = ev; x.e_done = ed;
      tbl.push_back(x);
   endfunction

   initial begin
`ifndef PISO_PARITY_EN
      // MSB first, 1011 -> 1,0,1,1 then idle
      add_vec(4'b1011, 1, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 1);
      add_vec(4'b0000, 0, 1, 0, 0, 0);
      // LSB first, 1011 -> 1,1,0,1 then idle
      add_vec(4'b1011, 1, 0, 1, 1, 0);
      add_vec(4'b0000, 0, 0, 1, 1, 0);
      add_vec(4'b0000, 0, 0, 0, 1, 0);
      add_vec(4'b0000, 0, 0, 1, 1, 1);
      add_vec(4'b0000, 0, 0, 0, 0, 0);
      // Back-to-back MSB first: 1100 then 0011 during its last bit
      add_vec(4'b1100, 1, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 1);
      add_vec(4'b0011, 1, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 1);
      add_vec(4'b0000, 0, 1, 0, 0, 0);
      // Stability: 0110 LSB first while inputs toggle and load_valid stays high
      add_vec(4'b0110, 1, 0, 0, 1, 0);
      add_vec(4'b1001, 1, 1, 1, 1, 0);
      add_vec(4'b0110, 1, 0, 1, 1, 0);
      add_vec(4'b1111, 1, 1, 0, 1, 1);
      add_vec(4'b0000, 0, 0, 0, 0, 0);
`else
      // Parity: 0111 MSB first -> 0,1,1,1, parity 1; then 0101 -> parity 0
      add_vec(4'b0111, 1, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 1);
      add_vec(4'b0101, 1, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 0);
      add_vec(4'b0000, 0, 1, 1, 1, 0);
      add_vec(4'b0000, 0, 1, 0, 1, 1);
      add_vec(4'b0000, 0, 1, 0, 0, 0);
`endif

      // Reset state and release
      exp_cur = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", '0);
      rst = 1'b1;
      #1;
      checkOutput("release_same_cycle", '0);
      @(posedge clk);
      #1;
      exp_cur = 5'b00001;
      checkOutput("first_ready", exp_cur);

      // Directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         logic [2:0] act3;
         logic [2:0] exp3;
         applyStimulus(tbl[i].din, tbl[i].valid, tbl[i].mode, $sformatf("model_vec%0d", i));
         act3 = {sout, sout_valid, done};
         exp3 = {tbl[i].e_sout, tbl[i].e_valid, tbl[i].e_done};
         n_compared++;
         if (act3 !== exp3) begin
            n_mismatched++;
            $display("[TB] FAIL vec%0d: sout/valid/done got %b required %b", i, act3, exp3);
         end
      end

      // Reset mid-word after two bits of 1010
      applyStimulus(4'b1010, 1, 1, "rst_word_bit1");
      applyStimulus(4'b0000, 0, 1, "rst_word_bit2");
      #2;
      rst = 1'b0;
      #1;
      pend.delete();
      exp_cur = '0;
      checkOutput("rst_immediate", exp_cur);
      @(posedge clk);
      #1;
      checkOutput("rst_held", exp_cur);
      rst = 1'b1;
      applyStimulus(4'b0000, 0, 0, "rst_ready_after_release");
      applyStimulus(4'b0000, 0, 0, "rst_no_stray_bits");
      applyStimulus(4'b0000, 0, 0, "rst_still_idle");

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] d;
         logic         v;
         logic         m;
         d = W'($urandom_range(0, (1 << W) - 1));
         v = ($urandom_range(0, 3) != 0);
         m = 1'($urandom_range(0, 1));
         applyStimulus(d, v, m, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
